// File: rtl/sandbox_pkg.sv
// Shared types for the sandbox top: step width/type and the step sequencer states.
package sandbox_pkg;
    localparam int STEP_W         = 4;
    localparam int CLK_HZ_DEFAULT = 12_000_000;

    typedef logic [STEP_W-1:0] step_t;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        OFFER
    } seq_state_t;
endpackage

// File: rtl/dip_debounce.sv
// Two-flop synchroniser plus stability filter; output follows input only after
// it has held one value for DEB_CYC consecutive cycles.
module dip_debounce #(
    parameter int W       = 4,
    parameter int DEB_CYC = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] raw,
    output logic [W-1:0] deb
);
    localparam int CW = $clog2(DEB_CYC + 1);

    logic [W-1:0]  s1, s2, cand;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            cand <= '0;
            cnt  <= '0;
            deb  <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt == CW'(DEB_CYC - 1)) begin
                // counter parks here, so deb keeps reloading the stable value
                deb <= cand;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/dip_step_sequencer.sv
// Turns debounced DIP switches into a step value for the LED counter, offering
// each change over a valid/ready handshake aligned to the advance tick.
module dip_step_sequencer
    import sandbox_pkg::*;
#(
    parameter int CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int TICK_HZ     = 4,
    parameter int DEBOUNCE_US = 10_000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [STEP_W-1:0] DIP_IN,
    output logic              tick_o,
    output logic [STEP_W-1:0] step_o,
    output logic              upd_valid_o,
    output logic [STEP_W-1:0] upd_step_o,
    input  logic              upd_ready_i,
    output logic              led_r_o,
    output logic              led_g_o,
    output logic              led_b_o
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int DEB_CYC  = CLK_HZ / 1_000_000 * DEBOUNCE_US;
    localparam int DIV_W    = $clog2(TICK_DIV);

    step_t             deb_q, new_step;
    logic [DIV_W-1:0]  div_cnt;
    logic              strobe;
    seq_state_t        state, state_nxt;
    logic              load_new, offer, accept;

    dip_debounce #(.W(STEP_W), .DEB_CYC(DEB_CYC)) u_deb (
        .clk (CLK),
        .rst (RST),
        .raw (DIP_IN),
        .deb (deb_q)
    );

    assign strobe = (div_cnt == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt <= '0;
        end else if (strobe) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_new  = 1'b0;
        offer     = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (deb_q != step_o) begin
                    load_new  = 1'b1;
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (deb_q == step_o) begin
                    state_nxt = IDLE;
                end else begin
                    load_new = 1'b1;
                    // a paused counter has no tick to wait for
                    if (strobe || step_o == '0) begin
                        offer     = 1'b1;
                        state_nxt = OFFER;
                    end
                end
            end
            OFFER: begin
                if (upd_valid_o && upd_ready_i) begin
                    accept    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tick_o      <= 1'b0;
            new_step    <= '0;
            step_o      <= '0;
            upd_valid_o <= 1'b0;
            upd_step_o  <= '0;
            led_b_o     <= 1'b0;
        end else begin
            // ticks landing on an open offer are dropped, not deferred
            tick_o <= strobe && (step_o != '0) && (state != OFFER);
            if (load_new) new_step <= deb_q;
            if (offer) begin
                upd_valid_o <= 1'b1;
                upd_step_o  <= new_step;
            end
            if (accept) begin
                step_o      <= upd_step_o;
                upd_valid_o <= 1'b0;
                led_b_o     <= ~led_b_o;
            end
        end
    end

    assign led_r_o = (state == PENDING) || (state == OFFER);
    assign led_g_o = (step_o != '0);
endmodule
